// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Optional feature macro: HILO_MADD_EN (enables madd/maddu accumulate ops).
package md_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops 6/7 are always reserved; 4/5 only exist when the accumulate feature is built.
    function automatic logic op_legal(input logic [2:0] op);
`ifdef HILO_MADD_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_sequencer_if.sv
// E-stage / hazard-unit facing bus of the HI/LO sequencer.
interface hilo_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations, observes status and HI/LO.
    modport master (
        output start, op, mt_hi, mt_lo, src_a, src_b, md_use_d,
        input  busy, stall_md, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, mt_hi, mt_lo, src_a, src_b, md_use_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Result is {res_hi,res_lo}.
// Optional feature macro: HILO_MADD_EN (adds {hi,lo} accumulate for ops 4/5).
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // with no overflow special case; signs are reapplied afterwards.
    always_comb begin
        prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u   = {32'd0, src_a} * {32'd0, src_b};
        div_zero = op_is_div(op) && (src_b == 32'd0);
        neg_a    = (op == MD_DIV) && src_a[31];
        neg_b    = (op == MD_DIV) && src_b[31];
        mag_a    = neg_a ? -src_a : src_a;
        mag_b    = neg_b ? -src_b : src_b;
        quot_u   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        rem_u    = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        quot     = (neg_a ^ neg_b) ? -quot_u : quot_u;
        rem      = neg_a ? -rem_u : rem_u;
        {res_hi, res_lo} = {hi, lo};
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV,
            MD_DIVU:  if (!div_zero) {res_hi, res_lo} = {rem, quot};
`ifdef HILO_MADD_EN
            MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MD_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
            default:  {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/hilo_sequencer.sv
// Fixed-latency multiply/divide sequencer owning architectural HI/LO.
// Optional feature macro: HILO_MADD_EN (madd/maddu accumulate into {hi,lo}).
module hilo_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic             clk,
    input  logic             reset,
    hilo_sequencer_if.slave  bus
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

    md_state_e             state;
    logic [MD_CNT_W-1:0]   cnt;
    logic [31:0]           shadow_hi;
    logic [31:0]           shadow_lo;
    logic                  shadow_dz;
    logic [31:0]           hi_reg;
    logic [31:0]           lo_reg;
    logic                  busy_reg;
    logic [31:0]           res_hi;
    logic [31:0]           res_lo;
    logic                  div_zero;

    // Accumulate operand is the committed {hi,lo}, which is stable while idle.
    md_compute u_compute (
        .op       (bus.op),
        .src_a    (bus.src_a),
        .src_b    (bus.src_b),
        .hi       (hi_reg),
        .lo       (lo_reg),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // Issue/countdown/commit FSM; requests arriving while running are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            busy_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            shadow_dz <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start) begin
                        // start always shadows a same-cycle mthi/mtlo, even if reserved
                        if (op_legal(bus.op)) begin
                            state     <= MD_RUN;
                            busy_reg  <= 1'b1;
                            cnt       <= op_is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
                            shadow_hi <= res_hi;
                            shadow_lo <= res_lo;
                            shadow_dz <= div_zero;
                        end
                    end else begin
                        if (bus.mt_hi) hi_reg <= bus.src_a;
                        if (bus.mt_lo) lo_reg <= bus.src_a;
                    end
                end
                MD_RUN: begin
                    if (cnt == '0) begin
                        state    <= MD_IDLE;
                        busy_reg <= 1'b0;
                        if (!shadow_dz) begin
                            hi_reg <= shadow_hi;
                            lo_reg <= shadow_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Stall must also cover the issue cycle, before busy is registered.
    assign bus.stall_md = bus.md_use_d & (busy_reg | bus.start);
    assign bus.busy     = busy_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: directed plan steps then random traffic
// against a cycles-remaining reference model with 64-bit reference arithmetic.
module tb_hilo_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    hilo_sequencer_if bus ();

    hilo_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    logic [31:0] p_hi, p_lo;
    logic        p_commit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [2:0] op);
`ifdef HILO_MADD_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    // Reference arithmetic straight from the ISA rules.
    task automatic ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p_commit = 1'b1;
        w = {m_hi, m_lo};
        case (op)
            3'd0: w = 64'(sa * sb);
            3'd1: w = {32'd0, a} * {32'd0, b};
            3'd2: if (b == 0) p_commit = 1'b0;
                  else begin
                      sq = sa / sb;
                      sr = sa % sb;
                      w = {sr[31:0], sq[31:0]};
                  end
            3'd3: if (b == 0) p_commit = 1'b0;
                  else w = {a % b, a / b};
            3'd4: w = {m_hi, m_lo} + 64'(sa * sb);
            3'd5: w = {m_hi, m_lo} + {32'd0, a} * {32'd0, b};
            default: ;
        endcase
        {p_hi, p_lo} = w;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_commit) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (bus.start) begin
            if (legal(bus.op)) begin
                m_left = (bus.op == 3'd2 || bus.op == 3'd3) ? DIV_N : MULT_N;
                ref_calc(bus.op, bus.src_a, bus.src_b);
            end
        end else begin
            if (bus.mt_hi) m_hi = bus.src_a;
            if (bus.mt_lo) m_lo = bus.src_a;
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic [2:0] op,
                         input logic mh, input logic ml, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d);
        reset = rst; bus.start = st; bus.op = op; bus.mt_hi = mh; bus.mt_lo = ml;
        bus.src_a = a; bus.src_b = b; bus.md_use_d = use_d;
    endtask

    // One cycle: check the combinational stall, clock, then check registered outputs.
    task automatic tick();
        logic exp_stall;
        #1;
        exp_stall = bus.md_use_d & ((m_left > 0) | bus.start);
        chk("stall_md", {31'd0, bus.stall_md}, {31'd0, exp_stall});
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d);
        int guard;
        drive(1'b0, 1'b1, op, 1'b0, 1'b0, a, b, use_d);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, use_d);
        guard = 0;
        while (m_left > 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("op_done_in_budget", {31'd0, m_left > 0}, 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("reset_hi", bus.hi, 32'd0);

        // mult -2*3 with D-stage md use: stall through issue and busy cycles
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        tick();

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        // back-to-back: no idle cycle between commit and next start
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'd0);

        run_op(3'd3, 32'd5, 32'd0, 1'b0);
        chk("divz_lo", bus.lo, 32'h8000_0000);
        chk("divz_hi", bus.hi, 32'd0);

        // mthi while busy is dropped
        drive(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h1234, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (5) tick();
        chk("mthi_busy_hi", bus.hi, 32'hFFFF_FFFF);

        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h1234, 32'd0, 1'b0);
        tick();
        chk("mthi_idle_hi", bus.hi, 32'h1234);

        // reset in RUN cycle 3 of a div aborts it
        drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) tick();
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("rst_abort_busy", {31'd0, bus.busy}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (12) tick();
        chk("rst_abort_hi", bus.hi, 32'd0);
        chk("rst_abort_lo", bus.lo, 32'd0);

        // reserved op and simultaneous start+mt
        drive(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 32'd1, 32'd1, 1'b1);
        tick();
        chk("reserved_busy", {31'd0, bus.busy}, 32'd0);
        run_op(3'd1, 32'd6, 32'd7, 1'b0);
        chk("multu_small_lo", bus.lo, 32'd42);

        // madd accumulate (reserved when the feature is absent)
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        run_op(3'd4, 32'd1, 32'd1, 1'b0);
`ifdef HILO_MADD_EN
        chk("madd_hi", bus.hi, 32'd1);
        chk("madd_lo", bus.lo, 32'd0);
`else
        chk("madd_off_hi", bus.hi, 32'd0);
        chk("madd_off_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        // random traffic, including requests while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, rand_word(), rand_word(),
                  1'($urandom_range(0, 1)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
